fetch_byte_queue: RTL and testbench
===================================

// Module: fetch_byte_queue
// PURPOSE
//  Parametrised successor to the core's fixed 128-byte fetch/decode buffer. Accepts little-endian
//  bus beats, drops bytes before the entry/redirect address at byte granularity, and presents a
//  WIN_BYTES window plus its PC to the decoder. Sits between bus response and decode; supports
//  variable-length consume and redirect flush, and drives a refill request level to the fetch FSM.
// PARAMETERS
//  BEAT_BYTES    8    bytes per bus beat (power of 2)
//  LINE_BYTES    64   fetch line size; redirect skip offset = addr mod LINE_BYTES (power of 2)
//  DEPTH_BYTES   128  queue capacity in bytes (power of 2, >= WIN_BYTES + BEAT_BYTES)
//  WIN_BYTES     15   decode window width (max x86 instruction length)
//  REFILL_THRESH 32   want_fetch asserted while count < REFILL_THRESH
// PORTS
//  clk           in  1                 clock, all state on rising edge
//  reset         in  1                 asynchronous, active-low (asserted when 0)
//  beat_valid    in  1                 bus beat present
//  beat_data     in  BEAT_BYTES*8      byte i = beat_data[8i+:8], lowest address first
//  beat_ready    out 1                 free space >= BEAT_BYTES (from registered count)
//  want_fetch    out 1                 count < REFILL_THRESH
//  redirect      in  1                 flush queue, restart at redirect_addr
//  redirect_addr in  64                new fetch PC
//  consume       in  1                 decoder retires consume_len bytes this cycle
//  consume_len   in  $clog2(WIN_BYTES+1)  bytes retired, legal 1..win_count
//  win_valid     out 1                 count >= WIN_BYTES
//  win_count     out $clog2(WIN_BYTES+1)  min(count, WIN_BYTES)
//  win_bytes     out WIN_BYTES*8       byte i = queue[rd+i] for i < count, else 8'h00
//  win_pc        out 64                address of win_bytes byte 0
//  count         out $clog2(DEPTH_BYTES)+1  bytes held
//  err           out 1                 sticky: over-consume or beat pushed when not ready
// BEHAVIOUR
//  - Reset (reset==0, async): rd=wr=0, skip_rem=0, win_pc=0, err=0; outputs settle to count=0,
//    beat_ready=1, want_fetch=1, win_valid=0, win_count=0, win_bytes=0. Storage not cleared.
//  - Pointers rd/wr are $clog2(DEPTH)+1 bits; count = wr-rd; storage index = ptr mod DEPTH_BYTES.
//  - Beat accept = beat_valid & beat_ready. If skip_rem >= BEAT_BYTES: drop beat, skip_rem -= BEAT_BYTES.
//    Else write bytes skip_rem..BEAT_BYTES-1 at wr, wr += BEAT_BYTES-skip_rem, skip_rem = 0.
//  - beat_valid & !beat_ready: beat discarded, err set (fetch must honour beat_ready).
//  - Consume: rd += consume_len, win_pc += consume_len (64-bit wrap). consume_len > count:
//    clamp to count, set err. consume_len==0 with consume=1 is a no-op.
//  - Same-cycle beat and consume both apply; beat_ready uses pre-consume count (no bypass).
//  - Redirect has priority: same-cycle beat and consume ignored (no err); rd=wr=0,
//    skip_rem = redirect_addr mod LINE_BYTES, win_pc = redirect_addr. Fetch FSM must issue
//    the new line aligned down to LINE_BYTES and discard old in-flight beats itself.
//  - Latency: accepted beat / consume / redirect visible on count and window next cycle.
//    win_bytes, win_valid, win_count, beat_ready, want_fetch are combinational from registers.
//  - Window reads across storage wrap (index DEPTH-1 -> 0) are contiguous.
//  - Full: count == DEPTH_BYTES legal; beat_ready=0 whenever count > DEPTH_BYTES-BEAT_BYTES.
// TESTING
//  1. redirect 0x1003; beat 0x0706050403020100 -> count=5, win_bytes[7:0]=0x03, win_pc=0x1003, win_valid=0.
//  2. redirect 0x1012 (skip 18); beats 0x00..07,0x08..0f,0x10..17 -> first two dropped, count=6, byte0=0x12.
//  3. redirect 0x0; push 16 beats -> count=128, beat_ready=0; held 17th beat waits; consume 8 -> beat_ready=1 next cycle.
//  4. Stream bytes 0..255 while consuming 13/cycle -> window stays sequential across index 127->0, win_pc advances by 13.
//  5. Redirect+beat+consume same cycle at count=40 -> next cycle count=0, win_pc=redirect_addr, err=0.
//  6. count=10, consume_len=15 -> count=0, err=1 and stays 1; reset low mid-stream -> all outputs to reset values immediately.

Source files
------------

// File: rtl/fetch_byte_queue_if.sv
// fetch_byte_queue_if: bus-beat, consume/redirect and decode-window signals of the fetch byte queue.
interface fetch_byte_queue_if #(
    parameter int BEAT_BYTES  = 8,
    parameter int WIN_BYTES   = 15,
    parameter int DEPTH_BYTES = 128
);
    logic                             beat_valid;
    logic [BEAT_BYTES*8-1:0]          beat_data;
    logic                             beat_ready;
    logic                             want_fetch;
    logic                             redirect;
    logic [63:0]                      redirect_addr;
    logic                             consume;
    logic [$clog2(WIN_BYTES+1)-1:0]   consume_len;
    logic                             win_valid;
    logic [$clog2(WIN_BYTES+1)-1:0]   win_count;
    logic [WIN_BYTES*8-1:0]           win_bytes;
    logic [63:0]                      win_pc;
    logic [$clog2(DEPTH_BYTES):0]     count;
    logic                             err;
    modport master (
        output beat_valid, beat_data, redirect, redirect_addr, consume, consume_len,
        input  beat_ready, want_fetch, win_valid, win_count, win_bytes, win_pc, count, err
    );
    modport slave (
        input  beat_valid, beat_data, redirect, redirect_addr, consume, consume_len,
        output beat_ready, want_fetch, win_valid, win_count, win_bytes, win_pc, count, err
    );
endinterface

// File: rtl/fetch_byte_queue.sv
// fetch_byte_queue: byte-granular fetch queue between bus beats and the decoder,
// with redirect skip, variable-length consume and a WIN_BYTES decode window.
module fetch_byte_queue #(
    parameter int BEAT_BYTES    = 8,
    parameter int LINE_BYTES    = 64,
    parameter int DEPTH_BYTES   = 128,
    parameter int WIN_BYTES     = 15,
    parameter int REFILL_THRESH = 32
) (
    input logic clk,
    input logic reset,
    fetch_byte_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH_BYTES) + 1;
    localparam int IW = $clog2(DEPTH_BYTES);
    localparam int SW = $clog2(LINE_BYTES);
    localparam int CW = $clog2(WIN_BYTES + 1);

    logic [7:0]    mem [DEPTH_BYTES];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, cnt, len;
    logic [SW-1:0] skip_q, skip_d;
    logic [63:0]   pc_q, pc_d;
    logic          err_q, err_d, acc, drop, over, wen;
    logic [WIN_BYTES*8-1:0] win;

    assign cnt            = wr_q - rd_q;
    assign bus.count      = cnt;
    assign bus.beat_ready = cnt <= PW'(DEPTH_BYTES - BEAT_BYTES);
    assign bus.want_fetch = cnt < PW'(REFILL_THRESH);
    assign bus.win_valid  = cnt >= PW'(WIN_BYTES);
    assign bus.win_count  = (cnt >= PW'(WIN_BYTES)) ? CW'(WIN_BYTES) : CW'(cnt);
    assign bus.win_bytes  = win;
    assign bus.win_pc     = pc_q;
    assign bus.err        = err_q;

    always_comb begin
        win = '0;
        for (int i = 0; i < WIN_BYTES; i++)
            if (PW'(i) < cnt) win[8*i +: 8] = mem[IW'(rd_q + PW'(i))];
    end

    always_comb begin
        acc    = bus.beat_valid && bus.beat_ready;
        drop   = int'(skip_q) >= BEAT_BYTES;
        over   = bus.consume && (PW'(bus.consume_len) > cnt);
        len    = !bus.consume ? '0 : over ? cnt : PW'(bus.consume_len);
        wen    = acc && !drop && !bus.redirect;
        rd_d   = '0;
        wr_d   = '0;
        skip_d = bus.redirect_addr[SW-1:0];
        pc_d   = bus.redirect_addr;
        err_d  = err_q;
        if (!bus.redirect) begin
            // Only bytes from skip_q upward belong to the stream; earlier ones precede the PC.
            wr_d   = wen ? wr_q + PW'(BEAT_BYTES) - PW'(skip_q) : wr_q;
            skip_d = !acc ? skip_q : drop ? skip_q - SW'(BEAT_BYTES) : '0;
            rd_d   = rd_q + len;
            pc_d   = pc_q + 64'(len);
            err_d  = err_q | (bus.beat_valid && !bus.beat_ready) | over;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q   <= '0;
            wr_q   <= '0;
            skip_q <= '0;
            pc_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            skip_q <= skip_d;
            pc_q   <= pc_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wen)
            for (int i = 0; i < BEAT_BYTES; i++)
                if (i >= int'(skip_q))
                    mem[IW'(wr_q + PW'(i) - PW'(skip_q))] <= bus.beat_data[8*i +: 8];
    end
endmodule

// File: tb/tb_fetch_byte_queue.sv
// tb_fetch_byte_queue: directed checks of skip, full/backpressure, wrap streaming,
// redirect priority, over-consume error and async reset.
module tb_fetch_byte_queue;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    fetch_byte_queue_if bus ();

    fetch_byte_queue dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bt(input int b);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = 8'(b + k);
        return r;
    endfunction

    task automatic idle();
        bus.beat_valid = 1'b0;
        bus.redirect   = 1'b0;
        bus.consume    = 1'b0;
    endtask

    task automatic redir(input logic [63:0] a);
        bus.redirect = 1'b1;
        bus.redirect_addr = a;
        tick();
        idle();
    endtask

    task automatic push(input int b);
        bus.beat_valid = 1'b1;
        bus.beat_data = bt(b);
        tick();
        idle();
    endtask

    task automatic take(input int n);
        bus.consume = 1'b1;
        bus.consume_len = 4'(n);
        tick();
        idle();
    endtask

    int rd, wr, base, n;
    bit bv, cs;
    logic [119:0] ew;

    initial begin
        idle();
        bus.beat_data = '0;
        bus.redirect_addr = '0;
        bus.consume_len = '0;
        tick();
        tick();
        chk("rst_count", 128'(bus.count), 128'(0));
        chk("rst_ready", 128'(bus.beat_ready), 128'(1));
        chk("rst_want", 128'(bus.want_fetch), 128'(1));
        chk("rst_wvalid", 128'(bus.win_valid), 128'(0));
        chk("rst_wcount", 128'(bus.win_count), 128'(0));
        chk("rst_wbytes", 128'(bus.win_bytes), 128'(0));
        chk("rst_pc", 128'(bus.win_pc), 128'(0));
        chk("rst_err", 128'(bus.err), 128'(0));
        reset = 1'b1;
        tick();

        redir(64'h1003);
        push(0);
        chk("t1_count", 128'(bus.count), 128'(5));
        chk("t1_byte0", 128'(bus.win_bytes[7:0]), 128'(8'h03));
        chk("t1_wbytes", 128'(bus.win_bytes), 128'(120'h0706050403));
        chk("t1_pc", 128'(bus.win_pc), 128'(64'h1003));
        chk("t1_wvalid", 128'(bus.win_valid), 128'(0));
        chk("t1_wcount", 128'(bus.win_count), 128'(5));

        redir(64'h1012);
        push(0);
        chk("t2_drop1", 128'(bus.count), 128'(0));
        push(8);
        chk("t2_drop2", 128'(bus.count), 128'(0));
        push(16);
        chk("t2_count", 128'(bus.count), 128'(6));
        chk("t2_wbytes", 128'(bus.win_bytes), 128'(120'h171615141312));

        redir(64'h0);
        for (int b = 0; b < 16; b++) push(8 * b);
        chk("t3_count", 128'(bus.count), 128'(128));
        chk("t3_ready", 128'(bus.beat_ready), 128'(0));
        chk("t3_want", 128'(bus.want_fetch), 128'(0));
        chk("t3_wvalid", 128'(bus.win_valid), 128'(1));
        chk("t3_wcount", 128'(bus.win_count), 128'(15));
        take(8);
        chk("t3_count2", 128'(bus.count), 128'(120));
        chk("t3_ready2", 128'(bus.beat_ready), 128'(1));
        chk("t3_pc", 128'(bus.win_pc), 128'(8));
        chk("t3_byte0", 128'(bus.win_bytes[7:0]), 128'(8'h08));
        push(128);
        chk("t3_count3", 128'(bus.count), 128'(128));
        chk("t3_err", 128'(bus.err), 128'(0));

        redir(64'h0);
        rd = 0;
        wr = 0;
        base = 0;
        for (int c = 0; c < 45; c++) begin
            n = wr - rd;
            bv = (base < 256) && (n <= 120);
            cs = n >= 13;
            bus.beat_valid = bv;
            bus.beat_data = bt(base);
            bus.consume = cs;
            bus.consume_len = 4'd13;
            tick();
            idle();
            if (cs) rd += 13;
            if (bv) begin
                wr += 8;
                base += 8;
            end
            ew = '0;
            for (int i = 0; i < 15; i++) if (i < wr - rd) ew[8*i +: 8] = 8'(rd + i);
            chk("t4_count", 128'(bus.count), 128'(wr - rd));
            chk("t4_pc", 128'(bus.win_pc), 128'(rd));
            chk("t4_win", 128'(bus.win_bytes), 128'(ew));
        end
        chk("t4_err", 128'(bus.err), 128'(0));

        redir(64'h0);
        for (int b = 0; b < 5; b++) push(8 * b);
        chk("t5_count40", 128'(bus.count), 128'(40));
        bus.redirect = 1'b1;
        bus.redirect_addr = 64'hdead_beef_0000_1234;
        bus.beat_valid = 1'b1;
        bus.beat_data = bt(40);
        bus.consume = 1'b1;
        bus.consume_len = 4'd5;
        tick();
        idle();
        chk("t5_count", 128'(bus.count), 128'(0));
        chk("t5_pc", 128'(bus.win_pc), 128'(64'hdead_beef_0000_1234));
        chk("t5_err", 128'(bus.err), 128'(0));

        redir(64'h0);
        push(0);
        push(8);
        take(6);
        chk("t6_count10", 128'(bus.count), 128'(10));
        take(15);
        chk("t6_count0", 128'(bus.count), 128'(0));
        chk("t6_err", 128'(bus.err), 128'(1));
        tick();
        tick();
        chk("t6_err_sticky", 128'(bus.err), 128'(1));
        push(16);
        chk("t6_count8", 128'(bus.count), 128'(8));
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_count", 128'(bus.count), 128'(0));
        chk("t6_rst_err", 128'(bus.err), 128'(0));
        chk("t6_rst_pc", 128'(bus.win_pc), 128'(0));
        chk("t6_rst_ready", 128'(bus.beat_ready), 128'(1));
        chk("t6_rst_wbytes", 128'(bus.win_bytes), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
